barcode_symbol_decoder: RTL and testbench
=========================================

// Module: barcode_symbol_decoder
// PURPOSE
//  Front-end stage directly upstream of the checkout datapath. Samples the raw
//  scanner line (1 = black bar), measures bar/space run lengths in clocks,
//  self-calibrates the narrow width from the start bar, and decodes a 5-bit
//  item code.
//  Output item_code/item_valid drives the datapath's I[4:0] input.
// PARAMETERS
//  CW     8   width of run-length counter; saturates at 2**CW-1
//  QUIET  16  consecutive space clocks forming a quiet zone (>=2, <2**CW)
//  MINU   2   minimum legal narrow width (clocks) measured on the start bar
// PORTS
//  clock       in   1  system clock, rising edge
//  reset       in   1  synchronous, active-high
//  bar_in      in   1  raw scanner line, 1 = bar, 0 = space; sampled into bar_q
//  item_code   out  5  last good decoded code, MSB first; held until next good
//  item_valid  out  1  1-cycle pulse, item_code updated in the same cycle
//  scan_error  out  1  1-cycle pulse on any malformed symbol
//  busy        out  1  high from start-bar detection until valid/error
// BEHAVIOUR
//  Reset: item_code=0, item_valid=0, scan_error=0, busy=0, bar_q=0,
//   counter=0, unit N=0, state=IDLE.
//  Reset mid-symbol aborts with no pulse; a fresh quiet zone is required.
//  Input: bar_q <= bar_in each clock.
//   - run counter <= 1 when bar_q changes, else +1 (saturating).
//   - Element width = count held at the change.
//  Symbol: quiet >= QUIET | start bar (defines N) | 5 x {space, data bar}
//   | space | stop bar | trailing quiet >= QUIET.
//  Classification, all integer arithmetic, no division:
//   - narrow: 2*w <= 3*N
//   - wide:   2*w > 3*N and w <= 4*N
//   - w > 4*N is illegal. Use CW+3-bit products.
//  Element rules:
//   - data bar: narrow=0, wide=1; first data bar = bit4.
//   - all spaces and the stop bar must be narrow.
//   - start bar must satisfy MINU <= w < 2**CW-1, else error.
//  FSM:
//   - IDLE: count spaces; at QUIET -> ARMED. A bar before QUIET resets the count.
//   - ARMED: bar_q rising -> CAL, busy=1.
//   - CAL: on bar end latch N=w -> SPACE.
//   - SPACE: on space end, classify; data bars done<5 -> DATA,
//     done=5 -> STOP, else error.
//   - DATA: on bar end, shift bit into shift register -> SPACE.
//   - STOP: on bar end, narrow -> TRAIL, else error.
//   - TRAIL: bar before QUIET -> error. Space count reaching QUIET
//     -> VALID (item_valid=1, item_code<=shift, busy=0) -> ARMED.
//  Error:
//   - Triggers: illegal width, or counter saturating while busy (stuck line).
//   - Action: scan_error=1 for one cycle, busy=0, shift cleared, -> IDLE
//     (full quiet zone needed again).
//  Latency: item_valid high in the cycle after the edge at which the QUIET-th
//   consecutive low sample of bar_q is counted.
//  Error timing: error pulses are raised in the cycle after the offending
//   transition (or saturation).
//  Never item_valid and scan_error in the same cycle.
//  Back-to-back symbols: the trailing quiet of one serves as the leading quiet
//   of the next (VALID -> ARMED).
// TESTING (QUIET=16, CW=8, MINU=2, narrow=4 clk, wide=8 clk)
//  1. 20 space, start bar 4, data 1,1,1,1,0 (wide x4, narrow), stop 4,
//     20 space -> item_valid once, item_code=30, busy low after.
//  2. Same framing, data 0,1,1,1,1 -> item_code=15.
//     Then symbol 1 again without a reset -> 30; item_code held between.
//  3. Data bar 20 clk (>4N) -> scan_error pulse, no item_valid,
//     item_code keeps previous value, busy=0.
//  4. Start bar 1 clk (<MINU), or only 10 quiet clocks before start
//     -> no busy, no valid; the symbol is ignored or errored per FSM.
//  5. bar_in stuck high 300 clk after start -> scan_error at saturation.
//     Following good symbol decodes correctly.
//  6. reset asserted during 3rd data bar -> all outputs 0 next cycle,
//     no pulse. The next symbol needs a full 16-clk quiet zone.

Source files
------------

// File: rtl/barcode_symbol_decoder.sv
// Barcode front end: samples the scanner line, measures run lengths, calibrates
// the narrow width from the start bar and decodes a 5-bit item code.
module barcode_symbol_decoder #(
  parameter int CW    = 8,
  parameter int QUIET = 16,
  parameter int MINU  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bar_in,
  output logic [4:0] item_code,
  output logic       item_valid,
  output logic       scan_error,
  output logic       busy
);

  localparam int PW = CW + 3;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] QLIM = CW'(QUIET);
  localparam logic [CW-1:0] MINL = CW'(MINU);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] CAL   = 3'd2;
  localparam logic [2:0] SPACE = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;
  localparam logic [2:0] TRAIL = 3'd6;

  logic          bar_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [4:0]    shift_q, shift_d;
  logic [2:0]    done_q, done_d;
  logic [4:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic          trans, bar_end, space_end, in_sym, sat, fail;
  logic [PW-1:0] w_x, n_x, two_w, three_n, four_n;
  logic          is_narrow, is_wide;

  // A transition is seen one edge early: cnt_q still holds the finished run.
  assign trans     = (bar_in != bar_q);
  assign bar_end   = trans &&  bar_q;
  assign space_end = trans && !bar_q;
  assign in_sym    = (state_q >= CAL);

  always_comb begin
    if (trans)              cnt_d = CW'(1);
    else if (cnt_q == CMAX) cnt_d = CMAX;
    else                    cnt_d = cnt_q + CW'(1);
  end

  assign sat = in_sym && !trans && (cnt_d == CMAX) && (cnt_q != CMAX);

  // Width classes against the calibrated unit, widened so nothing overflows.
  assign w_x       = PW'(cnt_q);
  assign n_x       = PW'(n_q);
  assign two_w     = w_x << 1;
  assign three_n   = n_x + (n_x << 1);
  assign four_n    = n_x << 2;
  assign is_narrow = (two_w <= three_n);
  assign is_wide   = !is_narrow && (w_x <= four_n);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    shift_d = shift_q;
    done_d  = done_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    fail    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bar_q && !trans && cnt_d >= QLIM) state_d = ARMED;
      end
      ARMED: begin
        if (trans && bar_in) state_d = CAL;
      end
      CAL: begin
        if (bar_end) begin
          if (cnt_q >= MINL && cnt_q != CMAX) begin
            n_d     = cnt_q;
            done_d  = 3'd0;
            shift_d = 5'd0;
            state_d = SPACE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      SPACE: begin
        if (space_end) begin
          if (!is_narrow)           fail = 1'b1;
          else if (done_q == 3'd5)  state_d = STOP;
          else                      state_d = DATA;
        end
      end
      DATA: begin
        if (bar_end) begin
          if (is_narrow || is_wide) begin
            shift_d = {shift_q[3:0], is_wide};
            done_d  = done_q + 3'd1;
            state_d = SPACE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      STOP: begin
        if (bar_end) begin
          if (is_narrow) state_d = TRAIL;
          else           fail = 1'b1;
        end
      end
      TRAIL: begin
        if (trans) begin
          fail = 1'b1;
        end else if (cnt_d == QLIM) begin
          valid_d = 1'b1;
          code_d  = shift_q;
          state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
    if (sat) fail = 1'b1;
    // Any malformed symbol demands a fresh quiet zone.
    if (fail) begin
      err_d   = 1'b1;
      valid_d = 1'b0;
      code_d  = code_q;
      shift_d = 5'd0;
      done_d  = 3'd0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bar_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
      n_q     <= '0;
      shift_q <= 5'd0;
      done_q  <= 3'd0;
      code_q  <= 5'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      bar_q   <= bar_in;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign item_code  = code_q;
  assign item_valid = valid_q;
  assign scan_error = err_q;
  assign busy       = in_sym;

endmodule

// File: tb/tb_barcode_symbol_decoder.sv
// Scoreboard bench: each symbol pushes its expected outcome; a monitor pops on
// every item_valid / scan_error pulse.
module tb_barcode_symbol_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       bar_in;
  logic [4:0] item_code;
  logic       item_valid;
  logic       scan_error;
  logic       busy;

  typedef struct {
    logic       is_err;
    logic [4:0] code;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  barcode_symbol_decoder #(.CW(8), .QUIET(16), .MINU(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .bar_in     (bar_in),
    .item_code  (item_code),
    .item_valid (item_valid),
    .scan_error (scan_error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic is_err, input logic [4:0] code);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    sb.push_back(e);
  endtask

  task automatic lvl(input logic v, input int n);
    bar_in = v;
    repeat (n) @(negedge clock);
  endtask

  // bad_i selects one data bar whose width is forced to bad_w; exp_busy < 0 skips the busy check.
  task automatic sym(input int lead, input int st, input logic [4:0] bits,
                     input int bad_i, input int bad_w, input int trail, input int exp_busy);
    lvl(1'b0, lead);
    lvl(1'b1, st);
    if (exp_busy >= 0) check("busy_after_start", busy, exp_busy);
    for (int i = 0; i < 5; i++) begin
      lvl(1'b0, 4);
      lvl(1'b1, (i == bad_i) ? bad_w : (bits[4-i] ? 8 : 4));
    end
    lvl(1'b0, 4);
    lvl(1'b1, 4);
    lvl(1'b0, trail);
  endtask

  always @(negedge clock) begin
    if (!reset && (item_valid || scan_error)) begin
      check("valid_err_exclusive", item_valid & scan_error, 0);
      if (sb.size() == 0) begin
        check("spurious_pulse", {item_valid, scan_error}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_is_error", scan_error, mon_e.is_err);
        if (!mon_e.is_err) check("item_code", item_code, mon_e.code);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    bar_in = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_code", item_code, 0);
    check("rst_valid", item_valid, 0);
    check("rst_err", scan_error, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Basic decode, then a second code, then back-to-back reuse of trailing quiet.
    push(1'b0, 5'd30);
    sym(20, 4, 5'b11110, -1, 0, 20, 1);
    check("t1_code", item_code, 30);
    check("t1_busy", busy, 0);
    push(1'b0, 5'd15);
    sym(20, 4, 5'b01111, -1, 0, 20, 1);
    check("t2_code", item_code, 15);
    push(1'b0, 5'd30);
    sym(20, 4, 5'b11110, -1, 0, 20, 1);
    check("t2b_code", item_code, 30);

    // Over-wide data bar: error, code held.
    push(1'b1, 5'd0);
    sym(20, 4, 5'b11110, 2, 20, 20, 1);
    check("t3_code_held", item_code, 30);
    check("t3_busy", busy, 0);

    // Start bar shorter than the minimum narrow width.
    push(1'b1, 5'd0);
    sym(20, 1, 5'b01111, -1, 0, 20, -1);
    check("t4a_code_held", item_code, 30);

    // Width boundaries: 6 clk (2w == 3N) is narrow, 16 clk (w == 4N) is wide, 17 illegal.
    push(1'b0, 5'd0);
    sym(20, 4, 5'b10000, 0, 6, 20, 1);
    check("t7_narrow_edge", item_code, 0);
    push(1'b0, 5'd8);
    sym(20, 4, 5'b00000, 1, 16, 20, 1);
    check("t7_wide_edge", item_code, 8);
    push(1'b1, 5'd0);
    sym(20, 4, 5'b00000, 3, 17, 20, 1);
    check("t7_illegal_held", item_code, 8);

    // Stuck-high line after the start bar saturates the counter.
    push(1'b1, 5'd0);
    lvl(1'b0, 20);
    lvl(1'b1, 10);
    check("t5_busy_stuck", busy, 1);
    lvl(1'b1, 290);
    check("t5_busy_after", busy, 0);
    lvl(1'b0, 20);
    push(1'b0, 5'd15);
    sym(20, 4, 5'b01111, -1, 0, 20, 1);
    check("t5_recover", item_code, 15);

    // Reset during the third data bar.
    lvl(1'b0, 20);
    lvl(1'b1, 4);
    lvl(1'b0, 4); lvl(1'b1, 8);
    lvl(1'b0, 4); lvl(1'b1, 8);
    lvl(1'b0, 4); lvl(1'b1, 3);
    reset  = 1'b1;
    bar_in = 1'b0;
    @(negedge clock);
    check("t6_code", item_code, 0);
    check("t6_valid", item_valid, 0);
    check("t6_err", scan_error, 0);
    check("t6_busy", busy, 0);
    reset = 1'b0;

    // Only 10 quiet clocks after reset: symbol ignored, no busy.
    sym(10, 4, 5'b11110, -1, 0, 20, 0);
    check("t4b_busy", busy, 0);
    check("t4b_code", item_code, 0);
    push(1'b0, 5'd15);
    sym(20, 4, 5'b01111, -1, 0, 20, 1);
    check("t6_next_code", item_code, 15);

    lvl(1'b0, 10);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
